// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
//   Shared types and constants for the front-of-pipe hazard controller.
//   - microcode_t   : decoded control word carried down the stages
//   - instr_data_t  : rs1/rs2/rd/imm operand fields
//   - MC_NOP        : bubble microcode (all-zero, so reg_we/check_rs*_dep = 0)
//   - ID_BUBBLE     : bubble instruction data (all-zero)
//   - DRAIN_CNT_W   : width of the hazard drain counter
// ---------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       imm_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       reg_we;
    logic       check_rs1_dep;
    logic       check_rs2_dep;
  } microcode_t;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } instr_data_t;

  // Bubble encodings: all-zero keeps the detector quiet for empty slots.
  localparam microcode_t  MC_NOP    = '0;
  localparam instr_data_t ID_BUBBLE = '0;

  // Drain counter holds up to DRAIN_CYCLES-1 with DRAIN_CYCLES <= 7.
  localparam int DRAIN_CNT_W = 3;

endpackage

// File: rtl/pipeline_stage_reg.sv
// ---------------------------------------------------------------------------
// pipeline_stage_reg
//   One pipeline stage register (microcode + instruction data).
//   Ports:
//     clk, rst_n  : clock, async active-low reset (resets to a bubble)
//     hold_i      : keep current contents
//     bubble_i    : load a bubble; wins over hold_i
//     mc_i/data_i : next-stage contents when neither hold nor bubble
//     mc_o/data_o : registered stage contents
// ---------------------------------------------------------------------------
module pipeline_stage_reg
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_i,
  input  logic        bubble_i,
  input  microcode_t  mc_i,
  input  instr_data_t data_i,
  output microcode_t  mc_o,
  output instr_data_t data_o
);

  microcode_t  mc_q;
  instr_data_t data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_q   <= MC_NOP;
      data_q <= ID_BUBBLE;
    end else if (bubble_i) begin
      mc_q   <= MC_NOP;
      data_q <= ID_BUBBLE;
    end else if (!hold_i) begin
      mc_q   <= mc_i;
      data_q <= data_i;
    end
  end

  assign mc_o   = mc_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Owns stage registers s0..s3 between decode and execute. On a data
//   dependency it freezes s0 and the decode handshake, drops bubbles into s1
//   for DRAIN_CYCLES cycles in total, and reports currently_blocked so the
//   detector masks the hazard while the older writer drains. Flush kills
//   s0/s1 and clears any pending drain.
//   Ports:
//     clk, rst_n                 : clock, async active-low reset
//     in_valid/in_ready          : decode handshake (in_ready = ~stall)
//     in_microcode/in_instruction_data : incoming decoded instruction
//     data_dependency            : hazard verdict (combinational from stages)
//     flush                      : branch/jump resolved in s2
//     microcode_s0..s3           : stage microcode registers
//     instruction_data_s0..s3    : stage operand registers
//     currently_blocked          : drain counter non-zero
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  microcode_t  in_microcode,
  input  instr_data_t in_instruction_data,
  input  logic        data_dependency,
  input  logic        flush,
  output microcode_t  microcode_s0,
  output microcode_t  microcode_s1,
  output microcode_t  microcode_s2,
  output microcode_t  microcode_s3,
  output instr_data_t instruction_data_s0,
  output instr_data_t instruction_data_s1,
  output instr_data_t instruction_data_s2,
  output instr_data_t instruction_data_s3,
  output logic        currently_blocked
);

  localparam int NUM_STAGES = 4;
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;
  logic                   stall;

  microcode_t  [NUM_STAGES-1:0] mc_d, mc_q;
  instr_data_t [NUM_STAGES-1:0] dat_d, dat_q;
  logic        [NUM_STAGES-1:0] hold, bubble;

  assign currently_blocked = (cnt_q != '0);
  assign stall             = data_dependency | currently_blocked;
  // in_ready ignores flush: a word taken in the flush cycle is killed by the
  // s0 bubble below, and decode drops its flushed fetch on its side.
  assign in_ready          = ~stall;

  // Drain counter. A hazard seen while already draining is ignored: the
  // detector masks it, and reloading would stretch the stall needlessly.
  always_comb begin
    cnt_d = cnt_q;
    if (flush)
      cnt_d = '0;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
    else if (data_dependency)
      cnt_d = DRAIN_LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Stage controls. Only s0 ever holds; s1 is where drain bubbles enter so
  // that the older instructions in s1..s3 keep flowing to write-back.
  always_comb begin
    hold      = '0;
    bubble    = '0;
    hold[0]   = stall;
    bubble[0] = flush | (~stall & ~in_valid);
    bubble[1] = flush | stall;
  end

  assign mc_d[0]  = in_microcode;
  assign dat_d[0] = in_instruction_data;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    if (i > 0) begin : g_chain
      assign mc_d[i]  = mc_q[i-1];
      assign dat_d[i] = dat_q[i-1];
    end

    pipeline_stage_reg u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .hold_i  (hold[i]),
      .bubble_i(bubble[i]),
      .mc_i    (mc_d[i]),
      .data_i  (dat_d[i]),
      .mc_o    (mc_q[i]),
      .data_o  (dat_q[i])
    );
  end

  assign microcode_s0        = mc_q[0];
  assign microcode_s1        = mc_q[1];
  assign microcode_s2        = mc_q[2];
  assign microcode_s3        = mc_q[3];
  assign instruction_data_s0 = dat_q[0];
  assign instruction_data_s1 = dat_q[1];
  assign instruction_data_s2 = dat_q[2];
  assign instruction_data_s3 = dat_q[3];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed bench for pipeline_hazard_ctrl. Instance u_a uses the default
//   DRAIN_CYCLES=3, instance u_b uses DRAIN_CYCLES=1. Instructions are tagged
//   by id in imm; a bubble reads back as all-zero.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A (DRAIN_CYCLES = 3)
  logic        a_vld, a_rdy, a_dd, a_fl, a_blk;
  microcode_t  a_mc_in;
  instr_data_t a_id_in;
  microcode_t  a_mc [4];
  instr_data_t a_id [4];

  // DUT B (DRAIN_CYCLES = 1)
  logic        b_vld, b_rdy, b_dd, b_fl, b_blk;
  microcode_t  b_mc_in;
  instr_data_t b_id_in;
  microcode_t  b_mc [4];
  instr_data_t b_id [4];

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_vld), .in_ready(a_rdy),
    .in_microcode(a_mc_in), .in_instruction_data(a_id_in),
    .data_dependency(a_dd), .flush(a_fl),
    .microcode_s0(a_mc[0]), .microcode_s1(a_mc[1]),
    .microcode_s2(a_mc[2]), .microcode_s3(a_mc[3]),
    .instruction_data_s0(a_id[0]), .instruction_data_s1(a_id[1]),
    .instruction_data_s2(a_id[2]), .instruction_data_s3(a_id[3]),
    .currently_blocked(a_blk)
  );

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_vld), .in_ready(b_rdy),
    .in_microcode(b_mc_in), .in_instruction_data(b_id_in),
    .data_dependency(b_dd), .flush(b_fl),
    .microcode_s0(b_mc[0]), .microcode_s1(b_mc[1]),
    .microcode_s2(b_mc[2]), .microcode_s3(b_mc[3]),
    .instruction_data_s0(b_id[0]), .instruction_data_s1(b_id[1]),
    .instruction_data_s2(b_id[2]), .instruction_data_s3(b_id[3]),
    .currently_blocked(b_blk)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic microcode_t mk_mc(input int id);
    microcode_t m = '0;
    m.alu_op        = id[3:0];
    m.reg_we        = 1'b1;
    m.check_rs1_dep = 1'b1;
    return m;
  endfunction

  function automatic instr_data_t mk_id(input int id);
    instr_data_t d = '0;
    d.rs1 = id[4:0];
    d.rd  = id[4:0];
    d.imm = id[31:0];
    return d;
  endfunction

  task automatic drv_a(input logic v, input int id, input logic dd, input logic fl);
    a_vld = v; a_mc_in = mk_mc(id); a_id_in = mk_id(id); a_dd = dd; a_fl = fl;
  endtask

  task automatic drv_b(input logic v, input int id, input logic dd, input logic fl);
    b_vld = v; b_mc_in = mk_mc(id); b_id_in = mk_id(id); b_dd = dd; b_fl = fl;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Gap/hazard schedule for the ordering test (bit i = cycle i).
  logic [15:0] t_vld = 16'h00BD;
  logic [15:0] t_dd  = 16'h000C;
  logic [15:0] t_rdy = 16'hFFE3;
  logic [31:0] seen [$];

  initial begin
    int pend;
    rst_n = 1'b0;
    drv_a(1'b0, 0, 1'b0, 1'b0);
    drv_b(1'b0, 0, 1'b0, 1'b0);
    #3;
    // Reset state
    for (int s = 0; s < 4; s++) begin
      check($sformatf("rst a_mc%0d", s), 64'(a_mc[s]), 64'(MC_NOP));
      check($sformatf("rst a_id%0d", s), 64'(a_id[s]), 64'(ID_BUBBLE));
    end
    check("rst a_blk", 64'(a_blk), 64'd0);
    check("rst a_rdy", 64'(a_rdy), 64'd1);
    check("rst b_rdy", 64'(b_rdy), 64'd1);
    step; step;
    rst_n = 1'b1;
    step;

    // 1: four back-to-back ops, no hazard
    for (int k = 1; k <= 4; k++) begin
      drv_a(1'b1, k, 1'b0, 1'b0);
      #1 check("t1 rdy", 64'(a_rdy), 64'd1);
      step;
      check("t1 s0", 64'(a_id[0].imm), 64'(k));
      check("t1 blk", 64'(a_blk), 64'd0);
    end
    check("t1 s3", 64'(a_id[3].imm), 64'd1);
    check("t1 s2", 64'(a_id[2].imm), 64'd2);
    check("t1 s1", 64'(a_id[1].imm), 64'd3);
    check("t1 mc3", 64'(a_mc[3]), 64'(mk_mc(1)));
    drv_a(1'b0, 0, 1'b0, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      step;
      check("t1 drain s3", 64'(a_id[3].imm), 64'(k));
      check("t1 gap s0", 64'(a_mc[0]), 64'(MC_NOP));
    end

    // 2: one-cycle hazard with DRAIN_CYCLES=3
    drv_a(1'b1, 9, 1'b0, 1'b0);  step;
    drv_a(1'b1, 10, 1'b0, 1'b0); step;
    drv_a(1'b1, 11, 1'b1, 1'b0);
    #1 check("t2 rdy T", 64'(a_rdy), 64'd0);
    step;
    check("t2 s0 T", 64'(a_id[0].imm), 64'd10);
    check("t2 s1 T", 64'(a_mc[1]), 64'(MC_NOP));
    check("t2 s2 T", 64'(a_id[2].imm), 64'd9);
    check("t2 blk T+1", 64'(a_blk), 64'd1);
    drv_a(1'b1, 11, 1'b0, 1'b0);
    #1 check("t2 rdy T+1", 64'(a_rdy), 64'd0);
    step;
    check("t2 s0 T+1", 64'(a_id[0].imm), 64'd10);
    check("t2 s1 T+1", 64'(a_mc[1]), 64'(MC_NOP));
    check("t2 s3 T+1", 64'(a_id[3].imm), 64'd9);
    check("t2 blk T+2", 64'(a_blk), 64'd1);
    #1 check("t2 rdy T+2", 64'(a_rdy), 64'd0);
    step;
    check("t2 s0 T+2", 64'(a_id[0].imm), 64'd10);
    check("t2 s1 T+2", 64'(a_mc[1]), 64'(MC_NOP));
    check("t2 blk T+3", 64'(a_blk), 64'd0);
    #1 check("t2 rdy T+3", 64'(a_rdy), 64'd1);
    step;
    check("t2 s0 adv", 64'(a_id[0].imm), 64'd11);
    check("t2 s1 adv", 64'(a_id[1].imm), 64'd10);
    drv_a(1'b0, 0, 1'b0, 1'b0);
    repeat (4) step;

    // 3: flush during drain, then flush with an accepted word
    drv_a(1'b1, 20, 1'b0, 1'b0); step;
    drv_a(1'b1, 21, 1'b0, 1'b0); step;
    drv_a(1'b1, 22, 1'b1, 1'b0); step;
    check("t3 blk", 64'(a_blk), 64'd1);
    drv_a(1'b1, 22, 1'b0, 1'b1);
    #1 check("t3 rdy fl", 64'(a_rdy), 64'd0);
    step;
    check("t3 s0 fl", 64'(a_mc[0]), 64'(MC_NOP));
    check("t3 s0d fl", 64'(a_id[0]), 64'(ID_BUBBLE));
    check("t3 s1 fl", 64'(a_mc[1]), 64'(MC_NOP));
    check("t3 s3 fl", 64'(a_id[3].imm), 64'd20);
    check("t3 blk fl", 64'(a_blk), 64'd0);
    drv_a(1'b1, 22, 1'b0, 1'b0);
    #1 check("t3 rdy res", 64'(a_rdy), 64'd1);
    step;
    check("t3 s0 res", 64'(a_id[0].imm), 64'd22);
    drv_a(1'b1, 23, 1'b0, 1'b1);
    #1 check("t3 rdy fl2", 64'(a_rdy), 64'd1);
    step;
    check("t3 s0 fl2", 64'(a_id[0].imm), 64'd0);
    check("t3 s1 fl2", 64'(a_id[1].imm), 64'd0);
    drv_a(1'b0, 0, 1'b0, 1'b0);
    repeat (4) step;

    // 4: asynchronous reset mid-drain (counter = 1)
    drv_a(1'b1, 30, 1'b0, 1'b0); step;
    drv_a(1'b1, 31, 1'b1, 1'b0); step;
    drv_a(1'b1, 31, 1'b0, 1'b0); step;
    check("t4 blk pre", 64'(a_blk), 64'd1);
    check("t4 s0 pre", 64'(a_id[0].imm), 64'd30);
    #2 rst_n = 1'b0;
    #1;
    check("t4 s0 rst", 64'(a_id[0]), 64'(ID_BUBBLE));
    check("t4 s2 rst", 64'(a_mc[2]), 64'(MC_NOP));
    check("t4 blk rst", 64'(a_blk), 64'd0);
    check("t4 rdy rst", 64'(a_rdy), 64'd1);
    drv_a(1'b0, 0, 1'b0, 1'b0);
    step;
    rst_n = 1'b1;
    step;
    check("t4 blk post", 64'(a_blk), 64'd0);
    check("t4 rdy post", 64'(a_rdy), 64'd1);

    // 5: DRAIN_CYCLES=1 build
    drv_b(1'b1, 40, 1'b0, 1'b0); step;
    drv_b(1'b1, 41, 1'b0, 1'b0); step;
    drv_b(1'b1, 42, 1'b1, 1'b0);
    #1 check("t5 rdy T", 64'(b_rdy), 64'd0);
    step;
    check("t5 s0 T", 64'(b_id[0].imm), 64'd41);
    check("t5 s1 T", 64'(b_mc[1]), 64'(MC_NOP));
    check("t5 s2 T", 64'(b_id[2].imm), 64'd40);
    check("t5 blk T+1", 64'(b_blk), 64'd0);
    drv_b(1'b1, 42, 1'b0, 1'b0);
    #1 check("t5 rdy T+1", 64'(b_rdy), 64'd1);
    step;
    check("t5 s0 adv", 64'(b_id[0].imm), 64'd42);
    check("t5 s1 adv", 64'(b_id[1].imm), 64'd41);
    check("t5 s3", 64'(b_id[3].imm), 64'd40);
    check("t5 blk", 64'(b_blk), 64'd0);
    drv_b(1'b0, 0, 1'b0, 1'b0);
    step;
    check("t5 s3 mc", 64'(b_mc[3]), 64'(MC_NOP));

    // 6: gaps interleaved with a hazard (plus a masked repeat) -> order kept
    pend = 50;
    for (int i = 0; i < 16; i++) begin
      drv_a(t_vld[i], pend, t_dd[i], 1'b0);
      #1 check($sformatf("t6 rdy c%0d", i), 64'(a_rdy), 64'(t_rdy[i]));
      if (t_vld[i] && a_rdy) pend++;
      step;
      if (a_id[3].imm != 0) seen.push_back(a_id[3].imm);
    end
    drv_a(1'b0, 0, 1'b0, 1'b0);
    check("t6 count", 64'(seen.size()), 64'd3);
    for (int j = 0; j < 3; j++)
      check($sformatf("t6 order%0d", j),
            64'((j < seen.size()) ? seen[j] : 32'd0), 64'(50 + j));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
